// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with glitch-free ratio updates.
// Each channel emits a registered divided clock and a CLK_IN-domain tick.
module clock_divider_multi #(
  parameter  int CHANNELS    = 2,
  parameter  int CNT_W       = 8,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK_IN,
  input  logic                RESET_N,
  input  logic [CHANNELS-1:0] RUN,
  input  logic                SYNC,
  input  logic                DIV_WR,
  input  logic [CH_W-1:0]     DIV_CH,
  input  logic [CNT_W-1:0]    DIV_VAL,
  output logic [CHANNELS-1:0] CLK_OUT,
  output logic [CHANNELS-1:0] TICK,
  output logic [CHANNELS-1:0] PENDING
);

  localparam logic [CNT_W-1:0] DEF_N   = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_CNT = CNT_W'(DEFAULT_DIV - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             wr_ok;
  logic [CNT_W-1:0] div_clamped;

  // Ratios below 2 cannot form a period, so they are lifted to 2.
  assign wr_ok       = DIV_WR && (int'(DIV_CH) < CHANNELS);
  assign div_clamped = (DIV_VAL < CNT_W'(2)) ? CNT_W'(2) : DIV_VAL;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] n_sync;
    logic [CNT_W:0]   half;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             hit;
    logic             bound;

    assign hit   = wr_ok && (int'(DIV_CH) == g);
    assign bound = (cnt_q == n_q - ONE);
    assign half  = ({1'b0, n_q} + (CNT_W + 1)'(1)) >> 1;

    always_comb begin
      cnt_d  = cnt_q;
      n_d    = n_q;
      p_d    = p_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      pend_d = pend_q;
      n_sync = n_q;
      if (SYNC) begin
        // Realign: a same-edge write outranks any older pending ratio.
        if (hit) begin
          n_sync = div_clamped;
        end else if (pend_q) begin
          n_sync = p_q;
        end
        n_d    = n_sync;
        p_d    = n_sync;
        cnt_d  = n_sync - ONE;
        clk_d  = 1'b0;
        pend_d = 1'b0;
      end else if (RUN[g]) begin
        if (bound) begin
          cnt_d  = '0;
          clk_d  = 1'b1;
          tick_d = 1'b1;
          if (hit) begin
            n_d    = div_clamped;
            p_d    = div_clamped;
            pend_d = 1'b0;
          end else if (pend_q) begin
            n_d    = p_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          clk_d = ({1'b0, cnt_d} < half);
          if (hit) begin
            p_d    = div_clamped;
            pend_d = 1'b1;
          end
        end
      end else begin
        // Frozen channel: adopt a waiting ratio, parked one step before wrap.
        if (hit) begin
          p_d    = div_clamped;
          pend_d = 1'b1;
        end else if (pend_q) begin
          n_d    = p_q;
          cnt_d  = p_q - ONE;
          pend_d = 1'b0;
        end
      end
    end

    always_ff @(posedge CLK_IN) begin
      if (!RESET_N) begin
        cnt_q  <= DEF_CNT;
        n_q    <= DEF_N;
        p_q    <= DEF_N;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        n_q    <= n_d;
        p_q    <= p_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
      end
    end

    assign CLK_OUT[g] = clk_q;
    assign TICK[g]    = tick_q;
    assign PENDING[g] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi.
// Phase-based reference model feeds an expected-output queue.
module tb_clock_divider_multi;

  localparam int CH   = 3;
  localparam int CW   = 8;
  localparam int DEF  = 2;
  localparam int CH_W = 2;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] run;
  logic          sync;
  logic          wr;
  logic [CH_W-1:0] wch;
  logic [CW-1:0] wval;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pend;

  clock_divider_multi #(
    .CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DEF)
  ) dut (
    .CLK_IN(clk), .RESET_N(rst_n), .RUN(run), .SYNC(sync),
    .DIV_WR(wr), .DIV_CH(wch), .DIV_VAL(wval),
    .CLK_OUT(clk_out), .TICK(tick), .PENDING(pend)
  );

  typedef struct packed {
    logic [CH-1:0] c;
    logic [CH-1:0] t;
    logic [CH-1:0] p;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit done = 0;

  // Reference: ratio, waiting ratio, phase within current period.
  int  m_n[CH];
  int  m_p[CH];
  int  m_ph[CH];
  bit  m_pend[CH];
  bit  m_clk[CH];
  bit  m_tick[CH];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model(input bit r, input logic [CH-1:0] ru,
                       input bit s, input bit w, input int c, input int v);
    int cv;
    int nn;
    exp_t e;
    cv = (v < 2) ? 2 : v;
    for (int i = 0; i < CH; i++) begin
      bit h;
      h = w && (c < CH) && (c == i);
      if (!r) begin
        m_n[i] = DEF; m_p[i] = DEF; m_ph[i] = DEF - 1;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else if (s) begin
        nn = h ? cv : (m_pend[i] ? m_p[i] : m_n[i]);
        m_n[i] = nn; m_p[i] = nn; m_ph[i] = nn - 1;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else if (ru[i]) begin
        if (m_ph[i] == m_n[i] - 1) begin
          m_ph[i] = 0;
          if (h) m_n[i] = cv;
          else if (m_pend[i]) m_n[i] = m_p[i];
          m_pend[i] = 0;
        end else begin
          m_ph[i]++;
          if (h) begin m_p[i] = cv; m_pend[i] = 1; end
        end
        m_clk[i]  = (2 * m_ph[i] < m_n[i]);
        m_tick[i] = (m_ph[i] == 0);
      end else begin
        m_tick[i] = 0;
        if (h) begin
          m_p[i] = cv; m_pend[i] = 1;
        end else if (m_pend[i]) begin
          m_n[i] = m_p[i]; m_ph[i] = m_p[i] - 1; m_pend[i] = 0;
        end
      end
      e.c[i] = m_clk[i];
      e.t[i] = m_tick[i];
      e.p[i] = m_pend[i];
    end
    q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [CH-1:0] ru,
                      input bit s, input bit w, input int c, input int v);
    @(negedge clk);
    rst_n = r; run = ru; sync = s; wr = w;
    wch = c[CH_W-1:0];
    wval = v[CW-1:0];
    model(r, ru, s, w, c, v);
  endtask

  task automatic idle(input int n, input logic [CH-1:0] ru);
    for (int k = 0; k < n; k++) step(1, ru, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (clk_out !== e.c) begin
          failures++;
          $display("FAIL clk_out t=%0t got=%b exp=%b", $time, clk_out, e.c);
        end
        checks++;
        if (tick !== e.t) begin
          failures++;
          $display("FAIL tick t=%0t got=%b exp=%b", $time, tick, e.t);
        end
        checks++;
        if (pend !== e.p) begin
          failures++;
          $display("FAIL pending t=%0t got=%b exp=%b", $time, pend, e.p);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; run = '0; sync = 0; wr = 0; wch = '0; wval = '0;
    // Reset then free run at default ratio.
    step(0, '1, 0, 0, 0, 0);
    step(0, '1, 0, 0, 0, 0);
    idle(6, '1);
    // Ratio 5 on ch0 mid-period.
    idle(1, '1);
    step(1, '1, 0, 1, 0, 5);
    idle(14, '1);
    // Clamped ratios on ch1, out-of-range channel.
    step(1, '1, 0, 1, 1, 0);
    idle(3, '1);
    step(1, '1, 0, 1, 1, 1);
    idle(3, '1);
    step(1, '1, 0, 1, 3, 9);
    idle(6, '1);
    // ch0=3, ch1=4, then realign.
    step(1, '1, 0, 1, 0, 3);
    step(1, '1, 0, 1, 1, 4);
    idle(8, '1);
    step(1, '1, 1, 0, 0, 0);
    idle(26, '1);
    // Freeze ch0 for 4 cycles.
    idle(1, '1);
    idle(4, 3'b110);
    idle(10, '1);
    // Reset with a pending write.
    step(1, '1, 0, 1, 2, 7);
    step(0, '1, 0, 0, 0, 0);
    idle(6, '1);
    // SYNC colliding with a write.
    step(1, '1, 1, 1, 2, 6);
    idle(10, '1);
    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit r, s, w;
      logic [CH-1:0] ru;
      int c, v;
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 39) == 0);
      w = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < CH; i++) ru[i] = ($urandom_range(0, 7) != 0);
      c = $urandom_range(0, 3);
      v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, 9);
      step(r, ru, s, w, c, v);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
